// File: rtl/time_count.sv
// Free-running 4-digit BCD seconds counter with a DIV-cycle rate divider and seven-segment outputs.
// Optional leading-zero blanking is enabled by defining TIME_COUNT_BLANK_EN.

module hex7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // Active-low segments, bit0 = a ... bit6 = g
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module time_count #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       SW,
  output logic       tick,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  localparam logic [25:0] RELOAD = 26'(DIV - 1);

  logic [25:0] div_cnt;
  logic [3:0]  d0, d1, d2, d3;
  logic [3:0]  d0_nxt, d1_nxt, d2_nxt, d3_nxt;
  logic        c1, c2, c3;
  logic [6:0]  raw0, raw1, raw2, raw3;

  assign tick = SW && (div_cnt == 26'd0);

  // Decimal increment; a digit at 9 rolls to 0 and carries upward, 9999 wraps to 0000
  always_comb begin
    c1     = (d0 == 4'd9);
    c2     = c1 && (d1 == 4'd9);
    c3     = c2 && (d2 == 4'd9);
    d0_nxt = c1 ? 4'd0 : d0 + 4'd1;
    d1_nxt = c1 ? ((d1 == 4'd9) ? 4'd0 : d1 + 4'd1) : d1;
    d2_nxt = c2 ? ((d2 == 4'd9) ? 4'd0 : d2 + 4'd1) : d2;
    d3_nxt = c3 ? ((d3 == 4'd9) ? 4'd0 : d3 + 4'd1) : d3;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt <= RELOAD;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
    end else if (SW) begin
      if (div_cnt == 26'd0) begin
        div_cnt <= RELOAD;
        d0      <= d0_nxt;
        d1      <= d1_nxt;
        d2      <= d2_nxt;
        d3      <= d3_nxt;
      end else begin
        div_cnt <= div_cnt - 26'd1;
      end
    end
  end

  hex7seg u_hex0 (.digit(d0), .seg(raw0));
  hex7seg u_hex1 (.digit(d1), .seg(raw1));
  hex7seg u_hex2 (.digit(d2), .seg(raw2));
  hex7seg u_hex3 (.digit(d3), .seg(raw3));

`ifdef TIME_COUNT_BLANK_EN
  // Blank a digit only when it and every more-significant digit are zero; ones always shown
  assign HEX3 = (d3 == 4'd0) ? 7'h7F : raw3;
  assign HEX2 = (d3 == 4'd0 && d2 == 4'd0) ? 7'h7F : raw2;
  assign HEX1 = (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) ? 7'h7F : raw1;
  assign HEX0 = raw0;
`else
  assign HEX3 = raw3;
  assign HEX2 = raw2;
  assign HEX1 = raw1;
  assign HEX0 = raw0;
`endif

endmodule

// File: tb/tb_time_count.sv
// Directed bench for time_count: two instances (DIV=4, DIV=2) plus an exhaustive decoder check.
module tb_time_count;
  logic       clk = 1'b0;
  logic       rst4 = 1'b1, sw4 = 1'b0, rst2 = 1'b1, sw2 = 1'b0;
  logic       tick4, tick2;
  logic [6:0] h40, h41, h42, h43, h20, h21, h22, h23;
  logic [3:0] dec_in;
  logic [6:0] dec_out;
  int n_assert = 0;
  int n_fail = 0;

`ifdef TIME_COUNT_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [6:0] Z = BLANK ? 7'h7F : 7'h40;

  always #5 clk = ~clk;

  time_count #(.DIV(4)) u4 (.CLOCK_50(clk), .reset(rst4), .SW(sw4), .tick(tick4),
                            .HEX0(h40), .HEX1(h41), .HEX2(h42), .HEX3(h43));
  time_count #(.DIV(2)) u2 (.CLOCK_50(clk), .reset(rst2), .SW(sw2), .tick(tick2),
                            .HEX0(h20), .HEX1(h21), .HEX2(h22), .HEX3(h23));
  hex7seg u_dec (.digit(dec_in), .seg(dec_out));

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] dec_tab [16];

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    dec_in = 4'd0;

    // Exhaustive decoder
    for (int i = 0; i < 16; i++) begin
      dec_in = 4'(i);
      #1;
      check($sformatf("decode_%0d", i), dec_out, dec_tab[i]);
    end

    // DIV=4: reset overrides SW
    sw4 = 1'b1;
    edges(2);
    check("rst_tick", tick4, 0);
    check("rst_hex0", h40, 7'h40);
    check("rst_hex1", h41, Z);
    check("rst_hex2", h42, Z);
    check("rst_hex3", h43, Z);
    check("rst_div", u4.div_cnt, 3);
    rst4 = 1'b0;
    edges(1);
    check("post_rst_tick", tick4, 0);
    edges(2);
    check("tick_c4", tick4, 1);
    check("hex0_pre1", h40, 7'h40);
    edges(1);
    check("tick_c4_end", tick4, 0);
    check("hex0_1", h40, 7'h79);
    edges(3);
    check("tick_c8", tick4, 1);
    edges(1);
    check("hex0_2", h40, 7'h24);
    edges(3);
    check("tick_c12", tick4, 1);
    edges(1);
    check("hex0_3", h40, 7'h30);

    // DIV=4 pause/resume
    rst4 = 1'b1;
    edges(2);
    rst4 = 1'b0;
    edges(6);
    check("pause_d0", h40, 7'h79);
    check("pause_div", u4.div_cnt, 1);
    sw4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("paused_tick", tick4, 0);
    end
    check("paused_hex0", h40, 7'h79);
    check("paused_div", u4.div_cnt, 1);
    sw4 = 1'b1;
    edges(1);
    check("resume_tick", tick4, 1);
    edges(1);
    check("resume_hex0", h40, 7'h24);
    check("resume_tick_end", tick4, 0);

    // DIV=4 reset at 0037 mid-interval
    rst4 = 1'b1;
    edges(1);
    rst4 = 1'b0;
    edges(37 * 4 + 2);
    check("c37_hex0", h40, 7'h78);
    check("c37_hex1", h41, 7'h30);
    check("c37_div", u4.div_cnt, 1);
    rst4 = 1'b1;
    edges(1);
    check("midrst_d", {u4.d3, u4.d2, u4.d1, u4.d0}, 16'h0000);
    check("midrst_div", u4.div_cnt, 3);
    check("midrst_hex0", h40, 7'h40);
    check("midrst_hex1", h41, Z);
    rst4 = 1'b0;
    edges(2);
    check("midrst_notick", tick4, 0);
    edges(1);
    check("midrst_tick4", tick4, 1);
    edges(1);
    check("midrst_hex0_1", h40, 7'h79);

    // DIV=2 long run with carries and wrap
    sw4 = 1'b0;
    rst2 = 1'b1;
    sw2 = 1'b1;
    edges(2);
    rst2 = 1'b0;
    edges(18);
    check("v9_hex0", h20, 7'h10);
    check("v9_hex1", h21, Z);
    edges(2);
    check("v10_hex0", h20, 7'h40);
    check("v10_hex1", h21, 7'h79);
    check("v10_hex2", h22, Z);
    edges(64);
    check("v42_hex0", h20, 7'h24);
    check("v42_hex1", h21, 7'h19);
    check("v42_hex2", h22, Z);
    check("v42_hex3", h23, Z);
    edges(114);
    check("v99_hex0", h20, 7'h10);
    check("v99_hex1", h21, 7'h10);
    edges(2);
    check("v100_hex0", h20, 7'h40);
    check("v100_hex1", h21, 7'h40);
    check("v100_hex2", h22, 7'h79);
    check("v100_hex3", h23, Z);
    edges(19998 - 200);
    check("v9999_hex0", h20, 7'h10);
    check("v9999_hex1", h21, 7'h10);
    check("v9999_hex2", h22, 7'h10);
    check("v9999_hex3", h23, 7'h10);
    check("v9999_notick", tick2, 0);
    edges(1);
    check("v9999_tick", tick2, 1);
    edges(1);
    check("wrap_hex0", h20, 7'h40);
    check("wrap_hex1", h21, Z);
    check("wrap_hex2", h22, Z);
    check("wrap_hex3", h23, Z);
    check("wrap_d", {u2.d3, u2.d2, u2.d1, u2.d0}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
